// File: rtl/pe_array_con_if.sv
// BRAM port bundle: pe_array_con drives it as master; my_bram / AXI BRAM controller port sits on the slave side.
interface pe_array_con_if;
    logic [31:0] BRAM_ADDR;
    logic [31:0] BRAM_WRDATA;
    logic [3:0]  BRAM_WE;
    logic        BRAM_CLK;
    logic [31:0] BRAM_RDDATA;

    modport master (output BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_CLK, input BRAM_RDDATA);
    modport slave  (input BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_CLK, output BRAM_RDDATA);
endinterface

// File: rtl/pe_array_con.sv
// Matrix-vector controller: loads a vector and NUM_ROWS rows from BRAM, runs NUM_PE parallel MAC lanes, writes one word per row.
// Latency 1+(V+RL)+(NUM_ROWS/NUM_PE)*(NUM_PE*V+RL+V+1+NUM_PE) cycles to done; no backpressure, BRAM takes one access per cycle.
module pe_array_con #(
    parameter int VECTOR_SIZE = 64,
    parameter int L_RAM_SIZE  = 6,
    parameter int NUM_PE      = 4,
    parameter int NUM_ROWS    = 8,
    parameter int RD_LATENCY  = 2,
    parameter int DONE_CYCLES = 5
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           start,
    output logic           done,
    output logic           busy,
    pe_array_con_if.master bram
);
    localparam int V    = VECTOR_SIZE;
    localparam int NGRP = NUM_ROWS / NUM_PE;
    localparam int RB   = V * (1 + NUM_ROWS);
    localparam int LW   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_VEC, LOAD_ROWS, CALC, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] grp_q, grp_d;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] wrdata_q, wrdata_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [31:0] acc_q [NUM_PE];
    logic [31:0] acc_d [NUM_PE];

    logic                  rdp_vld_q  [RD_LATENCY];
    logic                  rdp_row_q  [RD_LATENCY];
    logic [LW-1:0]         rdp_lane_q [RD_LATENCY];
    logic [L_RAM_SIZE-1:0] rdp_col_q  [RD_LATENCY];
    logic                  issue;
    logic [LW-1:0]         issue_lane;

    logic [31:0] vec_mem [V];
    logic [31:0] lram    [NUM_PE][V];
    logic [31:0] vec_rd_q;
    logic [31:0] lram_rd_q [NUM_PE];

    assign issue      = ((state_q == LOAD_VEC)  && (cnt_q < 32'(V))) ||
                        ((state_q == LOAD_ROWS) && (cnt_q < 32'(NUM_PE * V)));
    assign issue_lane = LW'(cnt_q >> L_RAM_SIZE);

    // Each read carries its destination down a pipe matching the BRAM read latency.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                rdp_vld_q[i]  <= 1'b0;
                rdp_row_q[i]  <= 1'b0;
                rdp_lane_q[i] <= '0;
                rdp_col_q[i]  <= '0;
            end
        end else begin
            rdp_vld_q[0]  <= issue;
            rdp_row_q[0]  <= (state_q == LOAD_ROWS);
            rdp_lane_q[0] <= issue_lane;
            rdp_col_q[0]  <= cnt_q[L_RAM_SIZE-1:0];
            for (int i = 1; i < RD_LATENCY; i++) begin
                rdp_vld_q[i]  <= rdp_vld_q[i-1];
                rdp_row_q[i]  <= rdp_row_q[i-1];
                rdp_lane_q[i] <= rdp_lane_q[i-1];
                rdp_col_q[i]  <= rdp_col_q[i-1];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (rdp_vld_q[RD_LATENCY-1]) begin
            if (rdp_row_q[RD_LATENCY-1])
                lram[rdp_lane_q[RD_LATENCY-1]][rdp_col_q[RD_LATENCY-1]] <= bram.BRAM_RDDATA;
            else
                vec_mem[rdp_col_q[RD_LATENCY-1]] <= bram.BRAM_RDDATA;
        end
        vec_rd_q <= vec_mem[cnt_q[L_RAM_SIZE-1:0]];
        for (int k = 0; k < NUM_PE; k++)
            lram_rd_q[k] <= lram[k][cnt_q[L_RAM_SIZE-1:0]];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grp_q    <= '0;
            waddr_q  <= '0;
            wrdata_q <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) acc_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grp_q    <= grp_d;
            waddr_q  <= waddr_d;
            wrdata_q <= wrdata_d;
            we_q     <= we_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            for (int k = 0; k < NUM_PE; k++) acc_q[k] <= acc_d[k];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        grp_d    = grp_q;
        waddr_d  = waddr_q;
        wrdata_d = wrdata_q;
        we_d     = 1'b0;
        for (int k = 0; k < NUM_PE; k++) acc_d[k] = acc_q[k];

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = LOAD_VEC;
                    grp_d   = '0;
                    waddr_d = '0;
                end
            end
            LOAD_VEC: begin
                if (cnt_q < 32'(V - 1)) waddr_d = 30'(cnt_q + 32'd1);
                if (cnt_q == 32'(V + RD_LATENCY - 1)) begin
                    state_d = LOAD_ROWS;
                    cnt_d   = '0;
                    waddr_d = 30'(V);
                end
            end
            LOAD_ROWS: begin
                if (cnt_q < 32'(NUM_PE * V - 1)) waddr_d = waddr_q + 30'd1;
                if (cnt_q == 32'(NUM_PE * V + RD_LATENCY - 1)) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    for (int k = 0; k < NUM_PE; k++) acc_d[k] = '0;
                end
            end
            CALC: begin
                // Cycle 0 only primes the local-RAM read registers; low 32 bits of the product are sign-agnostic.
                if (cnt_q != '0)
                    for (int k = 0; k < NUM_PE; k++) acc_d[k] = acc_q[k] + lram_rd_q[k] * vec_rd_q;
                if (cnt_q == 32'(V)) begin
                    state_d  = WRITE;
                    cnt_d    = '0;
                    waddr_d  = 30'(RB) + 30'(grp_q * 32'(NUM_PE));
                    wrdata_d = acc_d[0];
                    we_d     = 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q == 32'(NUM_PE - 1)) begin
                    cnt_d = '0;
                    if (grp_q == 32'(NGRP - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD_ROWS;
                        grp_d   = grp_q + 32'd1;
                        waddr_d = 30'(V) + 30'((grp_q + 32'd1) * 32'(NUM_PE * V));
                    end
                end else begin
                    we_d     = 1'b1;
                    waddr_d  = waddr_q + 30'd1;
                    wrdata_d = acc_q[LW'(cnt_q + 32'd1)];
                end
            end
            DONE: begin
                if (cnt_q == 32'(DONE_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    assign bram.BRAM_ADDR   = {waddr_q, 2'b00};
    assign bram.BRAM_WRDATA = wrdata_q;
    assign bram.BRAM_WE     = {4{we_q}};
    assign bram.BRAM_CLK    = aclk;
    assign done             = done_q;
    assign busy             = busy_q;
endmodule

// File: doc/pe_array_con.md
# pe_array_con

Parametrised matrix-vector controller, successor to `pe_con`. It reads one vector and an NUM_ROWS×VECTOR_SIZE signed integer matrix from a single-port BRAM. It computes NUM_PE row dot-products in parallel using per-PE local RAMs, writes one 32-bit result per row back to the same BRAM, and then signals `done`. It connects to `my_bram` and to the AXI BRAM controller port exactly as `pe_con` does.

## Interface
- VECTOR_SIZE, 64, elements per vector and per matrix row; must be a power of two.
- L_RAM_SIZE, 6, log2(VECTOR_SIZE); address width of each local RAM.
- NUM_PE, 4, number of parallel MAC lanes; must be ≥1.
- NUM_ROWS, 8, matrix rows; must be a multiple of NUM_PE.
- RD_LATENCY, 2, cycles from BRAM_ADDR presented to BRAM_RDDATA valid; legal range 1..4.
- DONE_CYCLES, 5, number of cycles `done` is held high.
- aclk  in  1  clock; also drives BRAM_CLK.
- aresetn  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- done  out  1  high for DONE_CYCLES cycles at the end of a run.
- busy  out  1  high in every state except IDLE.
- BRAM_ADDR  out  32  byte address, equal to word index × 4.
- BRAM_WRDATA  out  32  write data.
- BRAM_WE  out  4  byte write enables; 4'hF on a write, 4'h0 otherwise.
- BRAM_CLK  out  1  equal to aclk.
- BRAM_RDDATA  in  32  read data.

## Operation
- BRAM word map:
  - Vector at words 0..V-1, where V=VECTOR_SIZE.
  - Matrix row r at words V+r·V .. V+r·V+V-1.
  - Result for row r at word RB+r, where RB=V·(1+NUM_ROWS).
- States: IDLE → LOAD_VEC → LOAD_ROWS → CALC → WRITE, then either LOAD_ROWS (next group) or DONE → IDLE.
- IDLE: `start`=1 moves to LOAD_VEC. `start` is ignored in all other states.
- LOAD_VEC: issue one read per cycle for words 0..V-1. Each returned word goes into the vector RAM, tagged by a RD_LATENCY-deep valid/index pipeline.
- LOAD_ROWS, group g:
  - Rows g·NUM_PE .. g·NUM_PE+NUM_PE-1 are read row-major, one per cycle, NUM_PE·V reads in total.
  - Row k of the group fills local RAM k.
- CALC:
  - Accumulators clear on entry.
  - For j=0..V-1, every lane k computes acc_k += lram_k[j] · vec[j].
  - Signed 32×32 multiply; keep the low 32 bits. The accumulator wraps mod 2^32 with no saturation.
- WRITE: write acc_0..acc_{NUM_PE-1} to words RB+g·NUM_PE+k, one per cycle.
- DONE: hold `done`=1 for DONE_CYCLES cycles, then go to IDLE. The matrix and vector regions of BRAM are never written.

## Timing
- Reset values: done=0, busy=0, BRAM_ADDR=0, BRAM_WRDATA=0, BRAM_WE=0, state=IDLE. Accumulators and read pipelines are cleared.
- Reset mid-run: all of the above take effect immediately on aresetn low. BRAM writes already committed remain in BRAM. The next run needs a fresh `start`.
- `start` high at edge t gives the first read address (0) on BRAM_ADDR in cycle t+1.
- Reads are back-to-back with no bubbles. A load state exits RD_LATENCY cycles after its last address, once the final data has been captured.
- LOAD_VEC takes V+RD_LATENCY cycles. LOAD_ROWS takes NUM_PE·V+RD_LATENCY cycles.
- CALC takes V+1 cycles, including one local-RAM read cycle.
- WRITE takes NUM_PE cycles. BRAM_WE=4'hF only in those cycles, with address and data valid in the same cycle.
- Total run, from start edge to first `done` cycle: 1 + (V+RD_LATENCY) + (NUM_ROWS/NUM_PE)·(NUM_PE·V + RD_LATENCY + V + 1 + NUM_PE).
- BRAM_WE is 0 in every cycle outside WRITE. BRAM_ADDR holds its last value when the block is not accessing BRAM.
- `start` held high through the run and through DONE starts a second run on the first IDLE cycle after DONE.

## Test plan
- Configuration V=4, NUM_PE=2, NUM_ROWS=4, RD_LATENCY=2:
  - Stimulus: vector {1,2,3,4}; row r set to all (r+1).
  - Required: words 20..23 (byte addresses 80..92) = 10, 20, 30, 40.
  - Required: `done` high for 5 cycles; total latency = 1+6+2·(8+2+5+2) = 41 cycles.
- Signed and wrap case:
  - Vector {-1,2,0,0} with row {3,0x7FFFFFFF,0,0} gives 0xFFFFFFFB.
  - Vector {2,0,0,0} with row {0x7FFFFFFF,0,0,0} gives 0xFFFFFFFE.
- Default configuration (V=64, NUM_PE=4, NUM_ROWS=8):
  - Stimulus: identity-like rows (row r has 1 at column r), vector[i]=i+100.
  - Required: results at words 576..583 are 100..107.
  - Required: no write to any word below 576; BRAM_WE nonzero in exactly 8 cycles.
- Start robustness: pulse `start` again in LOAD_ROWS and in CALC. Required: no restart, and results identical to the unperturbed run.
- Reset mid-operation:
  - Drop aresetn during the second group's CALC.
  - Required: all outputs 0 in that same cycle; words for group 1 are unwritten.
  - A fresh `start` afterwards produces the correct full result set.
- RD_LATENCY=1 and RD_LATENCY=4 variants of the first scenario: same results, with latency adjusted per the formula.
